master_rd_completer: RTL and testbench

Completer-side read engine on the AXI master path of the PCIe transaction layer. Accepts one decoded memory-read request at a time from the RX router and issues a single AXI4 INCR read burst to the application. Buffers the returned R beats, then emits one completion header followed by the completion payload toward the TX arbiter. It is the responder counterpart to the slave request path, which turns AXI requests into TLPs.

---
 rtl/master_rd_completer_pkg.sv | 48 ++++
 rtl/master_rd_completer_beat_buffer.sv | 24 ++
 rtl/master_rd_completer.sv | 178 +++++++++++++++++
 tb/tb_master_rd_completer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/master_rd_completer_pkg.sv
// Shared types and constants for the completer-side
// AXI read engine (master_rd_completer).
package master_rd_completer_pkg;

  typedef enum logic [2:0] {
    CPL_SC = 3'b000,
    CPL_UR = 3'b001,
    CPL_CA = 3'b100
  } cpl_status_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_RDATA,
    S_HDR,
    S_DOUT
  } state_t;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

  localparam int         BEAT_BYTES = 32;
  localparam logic [2:0] ARSIZE_VAL = 3'b101;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef struct packed {
    logic [9:0]  tag;
    logic [15:0] requester_id;
    logic [9:0]  len_dw;
    logic [6:0]  lower_addr;
    logic [7:0]  last_idx;
  } rd_desc_t;

  // Beats touched by a read starting at byte offset off
  function automatic logic [7:0] calc_beats(
    input logic [4:0] off,
    input logic [9:0] len_dw
  );
    logic [12:0] len_bytes;
    logic [12:0] sum;
    len_bytes = (len_dw == 10'd0) ? 13'd4096
                                  : {1'b0, len_dw, 2'b00};
    sum = {8'd0, off} + len_bytes + 13'(BEAT_BYTES - 1);
    return sum[12:5];
  endfunction

endpackage

// File: rtl/master_rd_completer_beat_buffer.sv
// Beat buffer for master_rd_completer: one write port,
// one indexed read port, data is not reset.
module cpl_beat_buffer #(
  parameter int DEPTH      = 17,
  parameter int DATA_WIDTH = 256,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/master_rd_completer.sv
// Completer read engine: one MRd -> one AXI INCR burst,
// buffered R beats -> completion header + payload.
module master_rd_completer
  import master_rd_completer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 256,
  parameter int ID_WIDTH    = 4,
  parameter int AR_ID       = 0,
  parameter int MAX_READ_DW = 128
) (
  input  logic                  axi_clk,
  input  logic                  ARESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [9:0]            req_len_dw,
  input  logic [9:0]            req_tag,
  input  logic [15:0]           req_requester_id,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic [1:0]            ARBURST,
  output logic [ID_WIDTH-1:0]   ARID,
  input  logic                  RVALID,
  output logic                  RREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  output logic                  cpl_hdr_valid,
  input  logic                  cpl_hdr_ready,
  output logic [2:0]            cpl_status,
  output logic [11:0]           cpl_byte_count,
  output logic [6:0]            cpl_lower_addr,
  output logic [9:0]            cpl_length_dw,
  output logic [9:0]            cpl_tag,
  output logic [15:0]           cpl_requester_id,
  output logic                  cpl_data_valid,
  input  logic                  cpl_data_ready,
  output logic [DATA_WIDTH-1:0] cpl_data,
  output logic                  cpl_data_last
);

  localparam int BUF_DEPTH = (MAX_READ_DW * 4 + 31) / 32 + 1;
  localparam int IDX_W     = $clog2(BUF_DEPTH);
  localparam logic [9:0] MAX_DW = 10'(MAX_READ_DW);

  state_t                state, state_nx;
  rd_desc_t              desc;
  cpl_status_t           status;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]            cnt;
  logic [7:0]            rd_idx;
  logic [7:0]            beats;
  logic                  reject;
  logic                  r_fire;
  logic                  buf_we;
  logic                  force_ca;
  logic                  out_last;
  logic [DATA_WIDTH-1:0] buf_rdata;

  assign beats  = calc_beats(req_addr[4:0], req_len_dw);
  assign reject = (req_len_dw == 10'd0) ||
                  (req_len_dw > MAX_DW);

  assign r_fire = (state == S_RDATA) && RVALID;
  assign buf_we = r_fire && (cnt <= desc.last_idx);

  // Short burst or missing RLAST both mean a broken read
  assign force_ca = (RRESP == RRESP_SLVERR) ||
                    (RLAST ? (cnt != desc.last_idx)
                           : (cnt == desc.last_idx));

  assign out_last = (rd_idx == desc.last_idx);

  always_ff @(posedge axi_clk) begin
    if (ARESET) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    req_ready      = 1'b0;
    ARVALID        = 1'b0;
    RREADY         = 1'b0;
    cpl_hdr_valid  = 1'b0;
    cpl_data_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = reject ? S_HDR : S_AR;
      end
      S_AR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_nx = S_RDATA;
      end
      S_RDATA: begin
        RREADY = 1'b1;
        if (RVALID && RLAST) state_nx = S_HDR;
      end
      S_HDR: begin
        cpl_hdr_valid = 1'b1;
        if (cpl_hdr_ready)
          state_nx = (status == CPL_SC) ? S_DOUT : S_IDLE;
      end
      S_DOUT: begin
        cpl_data_valid = 1'b1;
        if (cpl_data_ready && out_last) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (ARESET) begin
      desc     <= '0;
      status   <= CPL_SC;
      araddr_q <= '0;
      cnt      <= '0;
      rd_idx   <= '0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        desc.tag          <= req_tag;
        desc.requester_id <= req_requester_id;
        desc.len_dw       <= req_len_dw;
        desc.lower_addr   <= {req_addr[6:2], 2'b00};
        desc.last_idx     <= beats - 8'd1;
        araddr_q <= {req_addr[ADDR_WIDTH-1:5], 5'd0};
        status   <= reject ? CPL_UR : CPL_SC;
        cnt      <= '0;
        rd_idx   <= '0;
      end
      if (state == S_AR && ARREADY) cnt <= '0;
      if (r_fire) begin
        // Saturate one past the end so overrun beats are dropped
        if (cnt <= desc.last_idx) cnt <= cnt + 8'd1;
        if (force_ca)
          status <= CPL_CA;
        else if (RRESP == RRESP_DECERR && status != CPL_CA)
          status <= CPL_UR;
      end
      if (state == S_DOUT && cpl_data_ready)
        rd_idx <= rd_idx + 8'd1;
    end
  end

  cpl_beat_buffer #(
    .DEPTH      (BUF_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_buf (
    .clk   (axi_clk),
    .we    (buf_we),
    .waddr (cnt[IDX_W-1:0]),
    .wdata (RDATA),
    .raddr (rd_idx[IDX_W-1:0]),
    .rdata (buf_rdata)
  );

  assign ARADDR  = araddr_q;
  assign ARLEN   = desc.last_idx;
  assign ARSIZE  = ARSIZE_VAL;
  assign ARBURST = BURST_INCR;
  assign ARID    = ID_WIDTH'(AR_ID);

  assign cpl_status       = status;
  assign cpl_byte_count   = {desc.len_dw, 2'b00};
  assign cpl_lower_addr   = desc.lower_addr;
  assign cpl_length_dw    = (status == CPL_SC) ? desc.len_dw : 10'd0;
  assign cpl_tag          = desc.tag;
  assign cpl_requester_id = desc.requester_id;

  assign cpl_data      = (state == S_DOUT) ? buf_rdata : '0;
  assign cpl_data_last = (state == S_DOUT) && out_last;

endmodule

// File: tb/tb_master_rd_completer.sv
// Directed table-driven bench for master_rd_completer
// plus hand sequences for reset and backpressure.
module tb_master_rd_completer;
  import master_rd_completer_pkg::*;

  logic         axi_clk;
  logic         ARESET;
  logic         req_valid;
  logic         req_ready;
  logic [63:0]  req_addr;
  logic [9:0]   req_len_dw;
  logic [9:0]   req_tag;
  logic [15:0]  req_requester_id;
  logic         ARVALID;
  logic         ARREADY;
  logic [63:0]  ARADDR;
  logic [7:0]   ARLEN;
  logic [2:0]   ARSIZE;
  logic [1:0]   ARBURST;
  logic [3:0]   ARID;
  logic         RVALID;
  logic         RREADY;
  logic [255:0] RDATA;
  logic [1:0]   RRESP;
  logic         RLAST;
  logic         cpl_hdr_valid;
  logic         cpl_hdr_ready;
  logic [2:0]   cpl_status;
  logic [11:0]  cpl_byte_count;
  logic [6:0]   cpl_lower_addr;
  logic [9:0]   cpl_length_dw;
  logic [9:0]   cpl_tag;
  logic [15:0]  cpl_requester_id;
  logic         cpl_data_valid;
  logic         cpl_data_ready;
  logic [255:0] cpl_data;
  logic         cpl_data_last;

  master_rd_completer dut (
    .axi_clk          (axi_clk),
    .ARESET           (ARESET),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_len_dw       (req_len_dw),
    .req_tag          (req_tag),
    .req_requester_id (req_requester_id),
    .ARVALID          (ARVALID),
    .ARREADY          (ARREADY),
    .ARADDR           (ARADDR),
    .ARLEN            (ARLEN),
    .ARSIZE           (ARSIZE),
    .ARBURST          (ARBURST),
    .ARID             (ARID),
    .RVALID           (RVALID),
    .RREADY           (RREADY),
    .RDATA            (RDATA),
    .RRESP            (RRESP),
    .RLAST            (RLAST),
    .cpl_hdr_valid    (cpl_hdr_valid),
    .cpl_hdr_ready    (cpl_hdr_ready),
    .cpl_status       (cpl_status),
    .cpl_byte_count   (cpl_byte_count),
    .cpl_lower_addr   (cpl_lower_addr),
    .cpl_length_dw    (cpl_length_dw),
    .cpl_tag          (cpl_tag),
    .cpl_requester_id (cpl_requester_id),
    .cpl_data_valid   (cpl_data_valid),
    .cpl_data_ready   (cpl_data_ready),
    .cpl_data         (cpl_data),
    .cpl_data_last    (cpl_data_last)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  typedef struct {
    logic [63:0] addr;
    logic [9:0]  len;
    logic [9:0]  tag;
    logic [15:0] rid;
    int          nret;
    int          err_idx;
    logic [1:0]  err_resp;
    bit          bp;
    bit          exp_rej;
    logic [63:0] exp_araddr;
    logic [7:0]  exp_arlen;
    logic [2:0]  exp_st;
    logic [11:0] exp_bc;
    logic [6:0]  exp_la;
    logic [9:0]  exp_len;
    int          exp_nout;
  } vec_t;

  vec_t vecs [11];
  int passed = 0;
  int total  = 0;
  int cur    = 0;

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL v%0d %s: got %0h expected %0h",
                  cur, nm, act, exp);
  endtask

  function automatic logic [255:0] bd(input int v, input int i);
    return {8{32'hC0DE0000 + 32'(v * 32 + i)}};
  endfunction

  task automatic chk_hdr(input vec_t t);
    chk("hdr_valid", 256'(cpl_hdr_valid), 256'(1'b1));
    chk("status", 256'(cpl_status), 256'(t.exp_st));
    chk("byte_count", 256'(cpl_byte_count), 256'(t.exp_bc));
    chk("lower_addr", 256'(cpl_lower_addr), 256'(t.exp_la));
    chk("length_dw", 256'(cpl_length_dw), 256'(t.exp_len));
    chk("tag", 256'(cpl_tag), 256'(t.tag));
    chk("rid", 256'(cpl_requester_id), 256'(t.rid));
  endtask

  task automatic chk_ar(input vec_t t);
    chk("arvalid", 256'(ARVALID), 256'(1'b1));
    chk("araddr", 256'(ARADDR), 256'(t.exp_araddr));
    chk("arlen", 256'(ARLEN), 256'(t.exp_arlen));
  endtask

  task automatic run(input vec_t t, input int id);
    cur = id;
    req_addr         = t.addr;
    req_len_dw       = t.len;
    req_tag          = t.tag;
    req_requester_id = t.rid;
    req_valid        = 1'b1;
    chk("req_ready_idle", 256'(req_ready), 256'(1'b1));
    @(negedge axi_clk);
    req_valid = 1'b0;
    if (!t.exp_rej) begin
      chk_ar(t);
      chk("arsize", 256'(ARSIZE), 256'(3'b101));
      chk("arburst", 256'(ARBURST), 256'(2'b01));
      chk("arid", 256'(ARID), 256'(4'd0));
      chk("req_ready_busy", 256'(req_ready), 256'(1'b0));
      if (t.bp) begin
        repeat (5) begin
          @(negedge axi_clk);
          chk_ar(t);
        end
      end
      ARREADY = 1'b1;
      @(negedge axi_clk);
      ARREADY = 1'b0;
      chk("arvalid_drop", 256'(ARVALID), 256'(1'b0));
      for (int i = 0; i < t.nret; i++) begin
        RVALID = 1'b1;
        RDATA  = bd(id, i);
        RRESP  = (i == t.err_idx) ? t.err_resp : RRESP_OKAY;
        RLAST  = (i == t.nret - 1);
        chk("rready", 256'(RREADY), 256'(1'b1));
        @(negedge axi_clk);
      end
      RVALID = 1'b0;
      RLAST  = 1'b0;
      RRESP  = RRESP_OKAY;
    end else begin
      chk("no_arvalid", 256'(ARVALID), 256'(1'b0));
    end
    chk_hdr(t);
    if (t.bp) begin
      repeat (2) @(negedge axi_clk);
      chk_hdr(t);
    end
    cpl_hdr_ready = 1'b1;
    @(negedge axi_clk);
    cpl_hdr_ready = 1'b0;
    for (int i = 0; i < t.exp_nout; i++) begin
      if (t.bp) begin
        chk("stall_data", cpl_data, bd(id, i));
        @(negedge axi_clk);
      end
      chk("data_valid", 256'(cpl_data_valid), 256'(1'b1));
      chk("data", cpl_data, bd(id, i));
      chk("data_last", 256'(cpl_data_last),
          256'(i == t.exp_nout - 1));
      cpl_data_ready = 1'b1;
      @(negedge axi_clk);
      cpl_data_ready = 1'b0;
    end
    chk("req_ready_done", 256'(req_ready), 256'(1'b1));
    chk("data_valid_off", 256'(cpl_data_valid), 256'(1'b0));
    chk("hdr_valid_off", 256'(cpl_hdr_valid), 256'(1'b0));
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_ready", 256'(req_ready), 256'(1'b1));
    chk("rst_arvalid", 256'(ARVALID), 256'(1'b0));
    chk("rst_rready", 256'(RREADY), 256'(1'b0));
    chk("rst_hdr_valid", 256'(cpl_hdr_valid), 256'(1'b0));
    chk("rst_data_valid", 256'(cpl_data_valid), 256'(1'b0));
    chk("rst_araddr", 256'(ARADDR), 256'(64'd0));
    chk("rst_arlen", 256'(ARLEN), 256'(8'd0));
    chk("rst_status", 256'(cpl_status), 256'(3'd0));
    chk("rst_byte_count", 256'(cpl_byte_count), 256'(12'd0));
    chk("rst_length", 256'(cpl_length_dw), 256'(10'd0));
    chk("rst_tag", 256'(cpl_tag), 256'(10'd0));
    chk("rst_data", cpl_data, 256'd0);
    chk("rst_last", 256'(cpl_data_last), 256'(1'b0));
  endtask

  initial begin
    vecs[0]  = '{64'h1000, 10'd8, 10'h011, 16'hABCD, 1, -1, 2'b00,
                 1'b0, 1'b0, 64'h1000, 8'd0, 3'd0, 12'd32, 7'h00,
                 10'd8, 1};
    vecs[1]  = '{64'h201C, 10'd16, 10'h022, 16'h1234, 3, -1, 2'b00,
                 1'b0, 1'b0, 64'h2000, 8'd2, 3'd0, 12'd64, 7'h1C,
                 10'd16, 3};
    vecs[2]  = '{64'h201C, 10'd16, 10'h3FF, 16'h5678, 3, -1, 2'b00,
                 1'b1, 1'b0, 64'h2000, 8'd2, 3'd0, 12'd64, 7'h1C,
                 10'd16, 3};
    vecs[3]  = '{64'h3000, 10'd32, 10'h055, 16'h0100, 4, 1, 2'b10,
                 1'b0, 1'b0, 64'h3000, 8'd3, 3'd4, 12'd128, 7'h00,
                 10'd0, 0};
    vecs[4]  = '{64'h4000, 10'd200, 10'h066, 16'h0200, 0, -1, 2'b00,
                 1'b0, 1'b1, 64'h0, 8'd0, 3'd1, 12'd800, 7'h00,
                 10'd0, 0};
    vecs[5]  = '{64'h5044, 10'd0, 10'h077, 16'h0300, 0, -1, 2'b00,
                 1'b0, 1'b1, 64'h0, 8'd0, 3'd1, 12'd0, 7'h44,
                 10'd0, 0};
    vecs[6]  = '{64'h6000, 10'd24, 10'h088, 16'h0400, 1, -1, 2'b00,
                 1'b0, 1'b0, 64'h6000, 8'd2, 3'd4, 12'd96, 7'h00,
                 10'd0, 0};
    vecs[7]  = '{64'h7010, 10'd4, 10'h099, 16'h0500, 1, 0, 2'b11,
                 1'b0, 1'b0, 64'h7000, 8'd0, 3'd1, 12'd16, 7'h10,
                 10'd0, 0};
    vecs[8]  = '{64'h8000, 10'd8, 10'h0AA, 16'h0600, 2, -1, 2'b00,
                 1'b0, 1'b0, 64'h8000, 8'd0, 3'd4, 12'd32, 7'h00,
                 10'd0, 0};
    vecs[9]  = '{64'h9004, 10'd128, 10'h0BB, 16'h0700, 17, -1, 2'b00,
                 1'b0, 1'b0, 64'h9000, 8'd16, 3'd0, 12'd512, 7'h04,
                 10'd128, 17};
    vecs[10] = '{64'hA000, 10'd129, 10'h0CC, 16'h0800, 0, -1, 2'b00,
                 1'b0, 1'b1, 64'h0, 8'd0, 3'd1, 12'h204, 7'h00,
                 10'd0, 0};

    ARESET           = 1'b1;
    req_valid        = 1'b0;
    req_addr         = '0;
    req_len_dw       = '0;
    req_tag          = '0;
    req_requester_id = '0;
    ARREADY          = 1'b0;
    RVALID           = 1'b0;
    RDATA            = '0;
    RRESP            = RRESP_OKAY;
    RLAST            = 1'b0;
    cpl_hdr_ready    = 1'b0;
    cpl_data_ready   = 1'b0;
    repeat (3) @(negedge axi_clk);
    ARESET = 1'b0;
    @(negedge axi_clk);
    cur = 90;
    chk_reset_vals();

    for (int k = 0; k < 11; k++) run(vecs[k], k);

    // Reset in the middle of a read burst
    cur              = 99;
    req_addr         = 64'h1000;
    req_len_dw       = 10'd32;
    req_tag          = 10'h123;
    req_requester_id = 16'hBEEF;
    req_valid        = 1'b1;
    @(negedge axi_clk);
    req_valid = 1'b0;
    ARREADY   = 1'b1;
    @(negedge axi_clk);
    ARREADY = 1'b0;
    RVALID  = 1'b1;
    RDATA   = bd(99, 0);
    RRESP   = RRESP_OKAY;
    RLAST   = 1'b0;
    chk("rready_mid", 256'(RREADY), 256'(1'b1));
    @(negedge axi_clk);
    ARESET = 1'b1;
    @(negedge axi_clk);
    RVALID = 1'b0;
    chk_reset_vals();
    ARESET = 1'b0;
    @(negedge axi_clk);
    run(vecs[0], 100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
